// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Holds the control-state encoding, counter sizing and the divide-by-zero quotient.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Widest divider the all-ones quotient helper can serve.
    localparam int DBZ_MAX_W = 256;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic logic [DBZ_MAX_W-1:0] dbz_quotient();
        return {DBZ_MAX_W{1'b1}};
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Run/Ready handshake and operand/result bundle of the sequential divider.
// The requester uses the master modport, the divider the slave modport.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             Run;
    logic             Signed_mode;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Ready;
    logic             Busy;
    logic             Div_by_zero;

    modport master (
        output Run, Signed_mode, Dividend, Divisor,
        input  Quotient, Remainder, Ready, Busy, Div_by_zero
    );

    modport slave (
        input  Run, Signed_mode, Dividend, Divisor,
        output Quotient, Remainder, Ready, Busy, Div_by_zero
    );
endinterface

// File: rtl/div_fsm.sv
// Control FSM of the sequential divider: owns state, step counter and sign flags,
// and issues load/step/fix strobes to the datapath.
import div_pkg::*;

module div_fsm #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic run_s,
    input  logic signed_mode_s,
    input  logic dividend_msb_s,
    input  logic divisor_msb_s,
    input  logic divisor_zero_s,
    output logic load_s,
    output logic step_s,
    output logic fix_s,
    output logic q_neg_r,
    output logic r_neg_r,
    output logic dbz_r,
    output logic busy_r
);
    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e       state_r;
    div_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;

    // State register.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and strobe decode; a zero divisor skips the iterations via FIX.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        fix_s       = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (run_s) begin
                    load_s = 1'b1;
                    if (divisor_zero_s) begin
                        state_nxt_s = FIX;
                    end else begin
                        state_nxt_s = ITER;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ITER: begin
                step_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = ITER;
                end
            end
            FIX: begin
                fix_s       = 1'b1;
                state_nxt_s = DONE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Step counter, sign flags and the registered Busy indication.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
            dbz_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            if (load_s) begin
                cnt_r   <= {CNT_W{1'b0}};
                q_neg_r <= signed_mode_s & (dividend_msb_s ^ divisor_msb_s);
                r_neg_r <= signed_mode_s & dividend_msb_s;
                dbz_r   <= divisor_zero_s;
            end else if (step_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            // The divide-by-zero pass through FIX is not a busy period.
            busy_r <= (state_r == ITER) | ((state_r == FIX) & ~dbz_r);
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (DIV/REM unit) with signed/unsigned mode and
// divide-by-zero reporting; datapath here, control in div_fsm.
import div_pkg::*;

module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          Reset_n,
    seq_divider_if.slave  bus
);
    localparam logic [DBZ_MAX_W-1:0] DBZ_FULL     = dbz_quotient();
    localparam logic [WIDTH-1:0]     DBZ_QUOTIENT = DBZ_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     ONE          = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             load_s;
    logic             step_s;
    logic             fix_s;
    logic             q_neg_r;
    logic             r_neg_r;
    logic             dbz_r;
    logic             busy_r;
    logic             divisor_zero_s;
    logic [WIDTH-1:0] dividend_mag_s;
    logic [WIDTH-1:0] divisor_mag_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvsr_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             ready_r;
    logic             div_by_zero_r;

    assign divisor_zero_s = (bus.Divisor == {WIDTH{1'b0}});

    div_fsm #(.WIDTH(WIDTH)) u_fsm (
        .clk            (clk),
        .Reset_n        (Reset_n),
        .run_s          (bus.Run),
        .signed_mode_s  (bus.Signed_mode),
        .dividend_msb_s (bus.Dividend[WIDTH-1]),
        .divisor_msb_s  (bus.Divisor[WIDTH-1]),
        .divisor_zero_s (divisor_zero_s),
        .load_s         (load_s),
        .step_s         (step_s),
        .fix_s          (fix_s),
        .q_neg_r        (q_neg_r),
        .r_neg_r        (r_neg_r),
        .dbz_r          (dbz_r),
        .busy_r         (busy_r)
    );

    // Operand magnitudes; the most negative value maps to its unsigned magnitude.
    always_comb begin
        if (bus.Signed_mode && bus.Dividend[WIDTH-1]) begin
            dividend_mag_s = ~bus.Dividend + ONE;
        end else begin
            dividend_mag_s = bus.Dividend;
        end
        if (bus.Signed_mode && bus.Divisor[WIDTH-1]) begin
            divisor_mag_s = ~bus.Divisor + ONE;
        end else begin
            divisor_mag_s = bus.Divisor;
        end
    end

    // One restoring step; the extra bit keeps the shifted partial remainder exact.
    always_comb begin
        rem_sh_s = {rem_r, quo_r[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, dvsr_r};
    end

    // Working registers and registered results.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rem_r         <= {WIDTH{1'b0}};
            quo_r         <= {WIDTH{1'b0}};
            dvsr_r        <= {WIDTH{1'b0}};
            quotient_r    <= {WIDTH{1'b0}};
            remainder_r   <= {WIDTH{1'b0}};
            ready_r       <= 1'b0;
            div_by_zero_r <= 1'b0;
        end else if (load_s) begin
            // On divide-by-zero the raw dividend is parked in Q to become the remainder.
            rem_r         <= {WIDTH{1'b0}};
            quo_r         <= divisor_zero_s ? bus.Dividend : dividend_mag_s;
            dvsr_r        <= divisor_mag_s;
            ready_r       <= 1'b0;
            div_by_zero_r <= 1'b0;
        end else if (step_s) begin
            if (!diff_s[WIDTH]) begin
                rem_r <= diff_s[WIDTH-1:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b1};
            end else begin
                rem_r <= rem_sh_s[WIDTH-1:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b0};
            end
        end else if (fix_s) begin
            if (dbz_r) begin
                quotient_r  <= DBZ_QUOTIENT;
                remainder_r <= quo_r;
            end else begin
                quotient_r  <= q_neg_r ? (~quo_r + ONE) : quo_r;
                remainder_r <= r_neg_r ? (~rem_r + ONE) : rem_r;
            end
            ready_r       <= 1'b1;
            div_by_zero_r <= dbz_r;
        end
    end

    assign bus.Quotient    = quotient_r;
    assign bus.Remainder   = remainder_r;
    assign bus.Ready       = ready_r;
    assign bus.Busy        = busy_r;
    assign bus.Div_by_zero = div_by_zero_r;

endmodule
